// File: rtl/target_sequencer_if.sv
// Round-controller signal bundle: game control/button inputs and round result outputs.
// master drives start/buttons and observes results; slave is the sequencer itself.
interface target_sequencer_if #(
   parameter int TIME_W = 16
);
   logic              start;
   logic              hit_in;
   logic              any_btn;
   logic [2:0]        sel;
   logic [7:0]        led;
   logic              busy;
   logic              done;
   logic [TIME_W-1:0] result;
   logic [1:0]        status;

   modport master (
      output start, hit_in, any_btn,
      input  sel, led, busy, done, result, status
   );

   modport slave (
      input  start, hit_in, any_btn,
      output sel, led, busy, done, result, status
   );
endinterface

// File: rtl/target_sequencer.sv
// Reaction-time game round controller: picks a random target, arms after a random delay,
// then times the player's response in clock cycles and reports one result per round.
module target_sequencer #(
   parameter int WAIT_MIN  = 4,
   parameter int WAIT_BITS = 2,
   parameter int TIMEOUT   = 20,
   parameter int TIME_W    = 16
) (
   input  logic               clk,
   input  logic               resetn,
   target_sequencer_if.slave  bus
);

   localparam int D_MAX = WAIT_MIN + (1 << WAIT_BITS) - 1;
   localparam int CNT_W = $clog2(D_MAX + 1);

   localparam logic [1:0] ST_HIT     = 2'b00;
   localparam logic [1:0] ST_FALSE   = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_WRONG   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_ACTIVE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TIME_W-1:0] rt_q, rt_d;
   logic [2:0]        sel_q, sel_d;
   logic [7:0]        led_q, led_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [TIME_W-1:0] result_q, result_d;
   logic [1:0]        status_q, status_d;

   // ARM counts down from D-1 to 0, giving exactly D ARM cycles.
   logic [CNT_W-1:0]  wait_load;
   assign wait_load = CNT_W'(WAIT_MIN - 1) + CNT_W'(lfsr_q[WAIT_BITS+2:3]);

   always_comb begin
      state_d  = state_q;
      lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      cnt_d    = cnt_q;
      rt_d     = rt_q;
      sel_d    = sel_q;
      led_d    = '0;
      result_d = result_q;
      status_d = status_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               sel_d   = lfsr_q[2:0];
               cnt_d   = wait_load;
               state_d = S_ARM;
            end
         end

         S_ARM: begin
            if (bus.any_btn) begin
               result_d = '0;
               status_d = ST_FALSE;
               state_d  = S_DONE;
            end else if (cnt_q == '0) begin
               rt_d    = '0;
               led_d   = 8'(1) << sel_q;
               state_d = S_ACTIVE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_ACTIVE: begin
            if (bus.hit_in) begin
               result_d = rt_q;
               status_d = ST_HIT;
               state_d  = S_DONE;
            end else if (bus.any_btn) begin
               result_d = rt_q;
               status_d = ST_WRONG;
               state_d  = S_DONE;
            end else if (rt_q == TIME_W'(TIMEOUT - 1)) begin
               result_d = TIME_W'(TIMEOUT);
               status_d = ST_TIMEOUT;
               state_d  = S_DONE;
            end else begin
               rt_d  = rt_q + 1'b1;
               led_d = led_q;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_ARM) || (state_d == S_ACTIVE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         lfsr_q   <= 16'hACE1;
         cnt_q    <= '0;
         rt_q     <= '0;
         sel_q    <= '0;
         led_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         cnt_q    <= cnt_d;
         rt_q     <= rt_d;
         sel_q    <= sel_d;
         led_q    <= led_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         status_q <= status_d;
      end
   end

   assign bus.sel    = sel_q;
   assign bus.led    = led_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.status = status_q;

endmodule

// File: tb/tb_target_sequencer.sv
// Randomized scoreboard bench for target_sequencer: stimulus pushes the predicted round
// outcome, an independent monitor pops and compares on every done pulse.
module tb_target_sequencer;

   localparam int WAIT_MIN  = 4;
   localparam int WAIT_BITS = 2;
   localparam int TIMEOUT   = 20;
   localparam int TIME_W    = 16;

   localparam int K_HIT     = 0;
   localparam int K_FALSE   = 1;
   localparam int K_TIMEOUT = 2;
   localparam int K_WRONG   = 3;
   localparam int K_RESET   = 4;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   target_sequencer_if #(.TIME_W(TIME_W)) bus ();

   target_sequencer #(
      .WAIT_MIN (WAIT_MIN),
      .WAIT_BITS(WAIT_BITS),
      .TIMEOUT  (TIMEOUT),
      .TIME_W   (TIME_W)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int result;
      int status;
      int sel;
      int cyc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [15:0] m_lfsr   = 16'hACE1;
   int          last_res = 0;
   int          last_st  = 0;
   int          last_sel = 0;
   logic [7:0]  sel_seen = '0;

   // Galois LFSR with mask 0xB400, written as shift-right-and-xor arithmetic.
   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      int v;
      v = int'(x);
      if (v % 2 == 1) v = (v / 2) ^ 32'h0000B400;
      else            v = v / 2;
      return 16'(v);
   endfunction

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      m_lfsr <= (!resetn) ? 16'hACE1 : lfsr_next(m_lfsr);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected done", 1, 0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("result", int'(bus.result), mon_e.result);
            chk("status", int'(bus.status), mon_e.status);
            chk("sel at done", int'(bus.sel), mon_e.sel);
            chk("done cycle", cyc, mon_e.cyc);
         end
      end
   end

   // One round, entered so that the next cycle is IDLE. Cycle i counts cycles after the start edge.
   task automatic run_round(input int kind, input int when, input bit both,
                            input bit hold, input bit noise);
      logic [15:0] lf;
      int   d, sel_e, k, dec_idx, done_idx, c0, lit_at;
      exp_t e;
      @(negedge clk);
      chk("pending done", sb_q.size(), 0);
      chk("idle busy", int'(bus.busy), 0);
      chk("idle led", int'(bus.led), 0);
      chk("hold sel", int'(bus.sel), last_sel);
      chk("hold result", int'(bus.result), last_res);
      chk("hold status", int'(bus.status), last_st);
      lf    = m_lfsr;
      sel_e = int'(lf) % 8;
      d     = WAIT_MIN + (int'(lf) / 8) % (1 << WAIT_BITS);
      c0    = cyc;
      case (kind)
         K_FALSE:   begin k = when % d;       dec_idx = 1 + k;     e.result = 0;       e.status = 1; end
         K_TIMEOUT: begin k = TIMEOUT - 1;    dec_idx = 1 + d + k; e.result = TIMEOUT; e.status = 2; end
         K_HIT:     begin k = when % TIMEOUT; dec_idx = 1 + d + k; e.result = k;       e.status = 0; end
         K_WRONG:   begin k = when % TIMEOUT; dec_idx = 1 + d + k; e.result = k;       e.status = 3; end
         default:   begin k = 2;              dec_idx = 1 + d + k; e.result = 0;       e.status = 0; end
      endcase
      done_idx = dec_idx + 1;
      e.sel    = sel_e;
      e.cyc    = c0 + done_idx;
      if (kind != K_RESET) sb_q.push_back(e);
      bus.start = 1'b1;
      lit_at    = 0;
      for (int i = 1; i <= done_idx; i++) begin
         @(negedge clk);
         if (i < done_idx) begin
            chk("busy", int'(bus.busy), 1);
            chk("sel", int'(bus.sel), sel_e);
            chk("led", int'(bus.led), (i <= d) ? 0 : (1 << sel_e));
         end
         if (i == 1) sel_seen[bus.sel] = 1'b1;
         if (lit_at == 0 && bus.led != 8'h00) lit_at = i;
         bus.start   = hold ? 1'b1 : ((noise && i < done_idx) ? 1'($urandom % 2) : 1'b0);
         bus.any_btn = 1'b0;
         bus.hit_in  = (i <= d && i < done_idx) ? 1'($urandom % 2) : 1'b0;
         if (i == dec_idx) begin
            case (kind)
               K_FALSE: bus.any_btn = 1'b1;
               K_HIT:   begin bus.hit_in = 1'b1; bus.any_btn = both ? 1'b1 : 1'($urandom % 2); end
               K_WRONG: begin bus.hit_in = 1'b0; bus.any_btn = 1'b1; end
               K_RESET: begin bus.hit_in = 1'b0; resetn = 1'b0; end
               default: ;
            endcase
         end
      end
      chk("done-cycle busy", int'(bus.busy), 0);
      chk("done-cycle led", int'(bus.led), 0);
      if (kind == K_RESET) begin
         chk("reset done", int'(bus.done), 0);
         chk("reset sel", int'(bus.sel), 0);
         chk("reset result", int'(bus.result), 0);
         chk("reset status", int'(bus.status), 0);
         resetn   = 1'b1;
         last_res = 0;
         last_st  = 0;
         last_sel = 0;
      end else begin
         last_res = e.result;
         last_st  = e.status;
         last_sel = e.sel;
      end
      if (kind != K_FALSE) begin
         chk("arm length", lit_at - 1, d);
         chk("arm length in range", int'((lit_at - 1) >= WAIT_MIN && (lit_at - 1) <= WAIT_MIN + 3), 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start   = 1'b0;
      bus.hit_in  = 1'b0;
      bus.any_btn = 1'b0;
      resetn      = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset sel", int'(bus.sel), 0);
      chk("reset led", int'(bus.led), 0);
      chk("reset busy", int'(bus.busy), 0);
      chk("reset done", int'(bus.done), 0);
      chk("reset result", int'(bus.result), 0);
      chk("reset status", int'(bus.status), 0);
      resetn = 1'b1;

      run_round(K_HIT, 5, 1'b0, 1'b0, 1'b0);
      run_round(K_FALSE, 2, 1'b0, 1'b0, 1'b0);
      run_round(K_WRONG, 3, 1'b0, 1'b0, 1'b0);
      run_round(K_HIT, 0, 1'b1, 1'b0, 1'b0);
      run_round(K_TIMEOUT, 0, 1'b0, 1'b0, 1'b0);
      run_round(K_HIT, 7, 1'b0, 1'b0, 1'b1);
      run_round(K_RESET, 0, 1'b0, 1'b0, 1'b0);

      sel_seen = '0;
      for (int r = 0; r < 64; r++)
         run_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                   1'($urandom % 2), 1'b1, 1'b0);
      bus.start = 1'b0;
      chk("all sel values seen", int'(sel_seen), 255);

      for (int r = 0; r < 20; r++)
         run_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                   1'($urandom % 2), 1'b0, 1'($urandom % 2));

      repeat (4) @(negedge clk);
      chk("final pending done", sb_q.size(), 0);
      chk("final idle busy", int'(bus.busy), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
